mfa_row_seq_mult: RTL and testbench

- Sequential unsigned multiplier that reuses one row of WIDTH mfa cells (AND-gated carry-save full adders) across WIDTH cycles, one partial-product row per cycle.
- Owns operand latching, row sequencing, carry-save state, the final carry-propagate add and the start/busy/done handshake.
- Sits between an operand source and any consumer of the 2*WIDTH-bit product. Area-reduced alternative to the fully unrolled mfa array.

---
 rtl/mfa_row_seq_mult.sv | 180 ++++++++++++++++++
 tb/tb_mfa_row_seq_mult.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfa_row_seq_mult.sv
// mfa_row_seq_mult
// Sequential unsigned multiplier. One row of WIDTH mfa cells (AND-gated
// carry-save full adders) is reused for WIDTH cycles, one partial-product
// row per cycle. A final WIDTH-bit ripple add resolves the carry-save pair
// into the upper half of the product.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request; sampled only while idle
//   x_in     multiplicand, latched on accept
//   y_in     multiplier, latched on accept
//   busy     high from the accept edge until done is asserted
//   done     one-cycle pulse; product is valid in that cycle
//   product  2*WIDTH-bit result, held until the next operation completes
//   row_idx  row currently being evaluated (0 outside RUN)
module mfa_row_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [WIDTH-1:0]           x_in,
  input  logic [WIDTH-1:0]           y_in,
  output logic                       busy,
  output logic                       done,
  output logic [2*WIDTH-1:0]         product,
  output logic [$clog2(WIDTH)-1:0]   row_idx
);

  localparam int RW = $clog2(WIDTH);
  localparam logic [RW-1:0] LAST_ROW = RW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]   x_q, x_d;
  logic [WIDTH-1:0]   y_q, y_d;
  // Only S[WIDTH-1:1] is kept: S[0] of every row is a finished product bit
  // and goes straight into the low half, so it never needs storing here.
  logic [WIDTH-2:0]   s_q, s_d;
  logic [WIDTH-1:0]   c_q, c_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [RW-1:0]      row_q, row_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   row_sum;
  logic [WIDTH-1:0]   row_carry;
  logic [WIDTH-1:0]   high_half;

  // One row of mfa cells. Cell k adds x[k]&ybit, S[k+1] and C[k]; S[WIDTH]
  // is 0. No carry moves horizontally inside the row.
  function automatic logic [2*WIDTH-1:0] mfa_row(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-2:0] s_hi,
    input logic [WIDTH-1:0] c,
    input logic             ybit
  );
    logic [WIDTH-1:0] s_ext;
    logic [WIDTH-1:0] s_new;
    logic [WIDTH-1:0] c_new;
    logic             a;
    s_ext = {1'b0, s_hi};
    for (int k = 0; k < WIDTH; k++) begin
      a        = x[k] & ybit;
      s_new[k] = a ^ s_ext[k] ^ c[k];
      c_new[k] = (a & s_ext[k]) | (a & c[k]) | (s_ext[k] & c[k]);
    end
    return {c_new, s_new};
  endfunction

  // WIDTH-bit ripple-carry add; the carry-out cannot be set because the
  // product never exceeds (2^WIDTH-1)^2.
  function automatic logic [WIDTH-1:0] ripple_add(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] sum;
    logic             cy;
    cy = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      sum[k] = a[k] ^ b[k] ^ cy;
      cy     = (a[k] & b[k]) | (a[k] & cy) | (b[k] & cy);
    end
    return sum;
  endfunction

  assign {row_carry, row_sum} = mfa_row(x_q, s_q, c_q, y_q[row_q]);
  // S >> 1 is exactly the stored upper bits of S.
  assign high_half = ripple_add({1'b0, s_q}, c_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (row_q == LAST_ROW) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy    = (state_q == RUN) || (state_q == FINISH);
    row_idx = (state_q == RUN) ? row_q : '0;
    done    = done_q;
    product = prod_q;
  end

  // Datapath next-state
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    s_d    = s_q;
    c_d    = c_q;
    lo_d   = lo_q;
    row_d  = row_q;
    prod_d = prod_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d   = x_in;
          y_d   = y_in;
          s_d   = '0;
          c_d   = '0;
          lo_d  = '0;
          row_d = '0;
        end
      end
      RUN: begin
        s_d          = row_sum[WIDTH-1:1];
        c_d          = row_carry;
        lo_d[row_q]  = row_sum[0];
        row_d        = (row_q == LAST_ROW) ? '0 : row_q + RW'(1);
      end
      FINISH: begin
        prod_d = {high_half, lo_q};
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      s_q    <= '0;
      c_q    <= '0;
      lo_q   <= '0;
      row_q  <= '0;
      prod_q <= '0;
      done_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      s_q    <= s_d;
      c_q    <= c_d;
      lo_q   <= lo_d;
      row_q  <= row_d;
      prod_q <= prod_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_mfa_row_seq_mult.sv
module tb_mfa_row_seq_mult;

  logic        clk;
  logic        rst_n;

  logic        start8;
  logic [7:0]  x8, y8;
  logic        busy8, done8;
  logic [15:0] prod8;
  logic [2:0]  row8;

  logic        start16;
  logic [15:0] x16, y16;
  logic        busy16, done16;
  logic [31:0] prod16;
  logic [3:0]  row16;

  int errors = 0;
  int checks = 0;
  int overlap = 0;

  mfa_row_seq_mult #(.WIDTH(8)) d8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .x_in(x8), .y_in(y8),
    .busy(busy8), .done(done8), .product(prod8), .row_idx(row8)
  );

  mfa_row_seq_mult #(.WIDTH(16)) d16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .x_in(x16), .y_in(y16),
    .busy(busy16), .done(done16), .product(prod16), .row_idx(row16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ((busy8 && done8) || (busy16 && done16)) overlap++;
  end

  // Drives one operation on the 8-bit unit and measures it; no checking.
  task automatic do_op8(input logic [7:0] x, input logic [7:0] y,
                        output int lat, output logic [15:0] p,
                        output int busy_cnt, output bit row_ok);
    @(negedge clk);
    start8 = 1'b1; x8 = x; y8 = y;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0; busy_cnt = 0; row_ok = 1'b1;
    while (!done8 && lat < 50) begin
      if (busy8) busy_cnt++;
      if (lat < 8 && row8 !== 3'(lat)) row_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    p = prod8;
  endtask

  task automatic do_op16(input logic [15:0] x, input logic [15:0] y,
                         output int lat, output logic [31:0] p);
    @(negedge clk);
    start16 = 1'b1; x16 = x; y16 = y;
    @(negedge clk);
    start16 = 1'b0;
    lat = 0;
    while (!done16 && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    p = prod16;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start8 = 1'b0; x8 = '0; y8 = '0;
    start16 = 1'b0; x16 = '0; y16 = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || prod8 !== 16'h0 || row8 !== 3'h0) begin
      errors++;
      $display("FAIL reset8: busy=%b done=%b product=%h row=%0d, required 0 0 0000 0",
               busy8, done8, prod8, row8);
    end
    checks++;
    if (busy16 !== 1'b0 || done16 !== 1'b0 || prod16 !== 32'h0 || row16 !== 4'h0) begin
      errors++;
      $display("FAIL reset16: busy=%b done=%b product=%h row=%0d, required all 0",
               busy16, done16, prod16, row16);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy8, done8);
    end
  endtask

  task automatic test_basic;
    int lat, bc; logic [15:0] p; bit rok;
    do_op8(8'd13, 8'd11, lat, p, bc, rok);
    checks++;
    if (p !== 16'd143) begin
      errors++; $display("FAIL basic_product: got %0d, required 143", p);
    end
    checks++;
    if (lat !== 9) begin
      errors++; $display("FAIL basic_latency: got %0d edges, required 9", lat);
    end
    checks++;
    if (bc !== 9) begin
      errors++; $display("FAIL basic_busy_cycles: got %0d, required 9", bc);
    end
    checks++;
    if (!rok) begin
      errors++; $display("FAIL basic_row_idx: sequence 0..7 got 0, required 1");
    end
    @(negedge clk);
    checks++;
    if (done8 !== 1'b0 || prod8 !== 16'd143) begin
      errors++;
      $display("FAIL done_single_pulse: done=%b product=%0d, required 0 143", done8, prod8);
    end
  endtask

  task automatic test_corners;
    int lat, bc; logic [15:0] p; bit rok;
    do_op8(8'd255, 8'd255, lat, p, bc, rok);
    checks++;
    if (p !== 16'hFE01 || lat !== 9) begin
      errors++; $display("FAIL max_operands: product=%h lat=%0d, required fe01 9", p, lat);
    end
    do_op8(8'd0, 8'd200, lat, p, bc, rok);
    checks++;
    if (p !== 16'h0 || lat !== 9) begin
      errors++; $display("FAIL zero_operand: product=%h lat=%0d, required 0000 9", p, lat);
    end
  endtask

  task automatic test_ignore_busy_start;
    int ndone, done_lat; logic [15:0] p;
    ndone = 0; done_lat = -1; p = '0;
    @(negedge clk);
    start8 = 1'b1; x8 = 8'd5; y8 = 8'd6;
    @(negedge clk);
    start8 = 1'b0;
    for (int lat = 0; lat < 25; lat++) begin
      if (lat == 3) begin start8 = 1'b1; x8 = 8'd7; y8 = 8'd7; end
      if (lat == 4) start8 = 1'b0;
      if (done8) begin ndone++; done_lat = lat; p = prod8; end
      @(negedge clk);
    end
    checks++;
    if (ndone !== 1 || done_lat !== 9) begin
      errors++; $display("FAIL ignore_start_done: pulses=%0d at %0d, required 1 at 9", ndone, done_lat);
    end
    checks++;
    if (p !== 16'd30 || prod8 !== 16'd30) begin
      errors++; $display("FAIL ignore_start_product: got %0d/%0d, required 30", p, prod8);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] xs [3];
    logic [7:0] ys [3];
    logic [15:0] exp_p [3];
    int done_t [3];
    logic [15:0] got_p [3];
    int nd, acc, stable_err;
    logic prev_done;
    logic [15:0] last;
    xs = '{8'd3, 8'd100, 8'd255};
    ys = '{8'd4, 8'd200, 8'd1};
    for (int i = 0; i < 3; i++) exp_p[i] = 16'(xs[i]) * 16'(ys[i]);
    nd = 0; acc = 0; stable_err = 0; prev_done = 1'b0; last = '0;
    for (int i = 0; i < 3; i++) begin done_t[i] = -1; got_p[i] = '0; end
    @(negedge clk);
    start8 = 1'b1; x8 = xs[0]; y8 = ys[0];
    @(negedge clk);
    acc = 1; x8 = xs[1]; y8 = ys[1];
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (prev_done && acc < 3) begin
        acc++;
        if (acc < 3) begin x8 = xs[acc]; y8 = ys[acc]; end
        else start8 = 1'b0;
      end
      if (done8) begin
        if (nd < 3) begin done_t[nd] = cyc; got_p[nd] = prod8; end
        nd++;
        last = prod8;
      end else if (nd > 0 && prod8 !== last) begin
        stable_err++;
      end
      prev_done = done8;
    end
    start8 = 1'b0;
    checks++;
    if (nd !== 3) begin
      errors++; $display("FAIL b2b_done_count: got %0d, required 3", nd);
    end
    checks++;
    if (done_t[0] !== 9 || done_t[1] - done_t[0] !== 10 || done_t[2] - done_t[1] !== 10) begin
      errors++;
      $display("FAIL b2b_spacing: done at %0d %0d %0d, required 9 19 29",
               done_t[0], done_t[1], done_t[2]);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_p[i] !== exp_p[i]) begin
        errors++; $display("FAIL b2b_product%0d: got %0d, required %0d", i, got_p[i], exp_p[i]);
      end
    end
    checks++;
    if (stable_err !== 0) begin
      errors++; $display("FAIL b2b_product_stable: %0d changes, required 0", stable_err);
    end
  endtask

  task automatic test_reset_mid;
    int ndone, lat, bc; logic [15:0] p; bit rok;
    @(negedge clk);
    start8 = 1'b1; x8 = 8'd200; y8 = 8'd150;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || prod8 !== 16'h0 || row8 !== 3'h0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b product=%h row=%0d, required 0 0 0000 0",
               busy8, done8, prod8, row8);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done8 || busy8) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++; $display("FAIL reset_no_done: %0d active cycles, required 0", ndone);
    end
    do_op8(8'd9, 8'd9, lat, p, bc, rok);
    checks++;
    if (p !== 16'd81 || lat !== 9) begin
      errors++; $display("FAIL after_reset_op: product=%0d lat=%0d, required 81 9", p, lat);
    end
  endtask

  task automatic test_random;
    int lat, bc, bad8, bad16; logic [15:0] p; bit rok;
    logic [31:0] p16;
    logic [7:0] a8, b8;
    logic [15:0] a16, b16;
    logic [31:0] exp16;
    bad8 = 0; bad16 = 0;
    for (int i = 0; i < 1500; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      if (i == 0) begin a8 = 8'hFF; b8 = 8'h01; end
      do_op8(a8, b8, lat, p, bc, rok);
      checks++;
      if (p !== 16'(a8) * 16'(b8) || lat !== 9 || !rok) begin
        errors++; bad8++;
        if (bad8 <= 5)
          $display("FAIL rand8 %0d*%0d: product=%0d lat=%0d, required %0d lat 9",
                   a8, b8, p, lat, 16'(a8) * 16'(b8));
      end
    end
    for (int i = 0; i < 800; i++) begin
      a16 = 16'($urandom); b16 = 16'($urandom);
      if (i == 0) begin a16 = 16'hFFFF; b16 = 16'hFFFF; end
      exp16 = 32'(a16) * 32'(b16);
      do_op16(a16, b16, lat, p16);
      checks++;
      if (p16 !== exp16 || lat !== 17) begin
        errors++; bad16++;
        if (bad16 <= 5)
          $display("FAIL rand16 %0d*%0d: product=%0d lat=%0d, required %0d lat 17",
                   a16, b16, p16, lat, exp16);
      end
    end
    checks++;
    if (overlap !== 0) begin
      errors++; $display("FAIL busy_done_overlap: %0d cycles, required 0", overlap);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_ignore_busy_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
